// File: rtl/mest_pro_out_sequencer.sv
// Output sequencer: buffers core words and plays them
// nibble by nibble into the 7-segment decoder stage.
module mest_pro_out_sequencer #(
  parameter int MEM_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int GAP_CYCLES   = 100,
  localparam int NUM_DIGITS  = MEM_WIDTH / 4,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr_valid,
  input  logic [MEM_WIDTH-1:0]  i_wr_data,
  output logic                  o_wr_ready,
  output logic [MEM_WIDTH-1:0]  o_mem_val,
  output logic                  o_output_enable,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_fifo_count
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMAX = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   =
    TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_TOP    = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHOW,
    S_GAP
  } state_t;

  logic [MEM_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic                 adv;

  state_t               state_q, state_d;
  logic [MEM_WIDTH-1:0] word_q, word_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [TW-1:0]        tmr_q, tmr_d;

  logic                  oe_d;
  logic [MEM_WIDTH-1:0]  val_d;
  logic [NUM_DIGITS-1:0] sel_d;
  logic [3:0]            nib;

  assign o_wr_ready   = (count != CNT_W'(FIFO_DEPTH));
  assign push         = i_wr_valid && o_wr_ready;
  assign o_fifo_count = count;
  assign o_busy       = (state_q != S_IDLE);

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state, current word, nibble index and phase timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      tmr_q   <= tmr_d;
    end
  end

  // Next-state: phase timing, nibble stepping and word pops
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    tmr_d   = tmr_q;
    pop     = 1'b0;
    adv     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          word_d  = mem[rd_ptr];
          idx_d   = IDX_TOP;
          tmr_d   = '0;
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (tmr_q == DWELL_LAST) begin
          tmr_d = '0;
          if (GAP_CYCLES != 0) state_d = S_GAP;
          else adv = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          tmr_d = '0;
          adv   = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (idx_q != '0) begin
        idx_d   = idx_q - IW'(1);
        state_d = S_SHOW;
      end else if (count != '0) begin
        pop     = 1'b1;
        word_d  = mem[rd_ptr];
        idx_d   = IDX_TOP;
        state_d = S_SHOW;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Output decode from next state so registered outputs track the FSM
  always_comb begin
    oe_d  = (state_d == S_SHOW);
    nib   = word_d[{idx_d, 2'b00} +: 4];
    val_d = oe_d ? MEM_WIDTH'(nib) : '0;
    sel_d = (state_d == S_IDLE) ? '0 : (NUM_DIGITS'(1) << idx_d);
  end

  // Registered decoder-facing outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_output_enable <= 1'b0;
      o_mem_val       <= '0;
      o_digit_sel     <= '0;
    end else begin
      o_output_enable <= oe_d;
      o_mem_val       <= val_d;
      o_digit_sel     <= sel_d;
    end
  end

endmodule

// File: tb/tb_mest_pro_out_sequencer.sv
// Directed bench for the output sequencer.
// Two instances: DWELL=4/GAP=2 and DWELL=3/GAP=0.
module tb_mest_pro_out_sequencer;

  logic        clk;
  logic        rst_n;
  logic        wv, v0;
  logic [15:0] wd, d0;
  logic        rdy, rdy0;
  logic [15:0] mv, mv0;
  logic        oe, oe0;
  logic [3:0]  sel, sel0;
  logic        busy, busy0;
  logic [2:0]  cnt, cnt0;

  int checks = 0;
  int errors = 0;

  mest_pro_out_sequencer #(
    .MEM_WIDTH(16), .FIFO_DEPTH(4),
    .DWELL_CYCLES(4), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(wv), .i_wr_data(wd),
    .o_wr_ready(rdy), .o_mem_val(mv),
    .o_output_enable(oe), .o_digit_sel(sel),
    .o_busy(busy), .o_fifo_count(cnt)
  );

  mest_pro_out_sequencer #(
    .MEM_WIDTH(16), .FIFO_DEPTH(4),
    .DWELL_CYCLES(3), .GAP_CYCLES(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_wr_valid(v0), .i_wr_data(d0),
    .o_wr_ready(rdy0), .o_mem_val(mv0),
    .o_output_enable(oe0), .o_digit_sel(sel0),
    .o_busy(busy0), .o_fifo_count(cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wv = 1'b1; wd = 16'hBEEF;
    v0 = 1'b1; d0 = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, oe, sel, mv, rdy, cnt} !== {2'b00, 4'h0, 16'h0, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i,
                 {busy, oe, sel, mv, rdy, cnt}, {2'b00, 4'h0, 16'h0, 1'b1, 3'd0});
      end
      checks++;
      if ({busy0, oe0, sel0, mv0, rdy0, cnt0} !== {2'b00, 4'h0, 16'h0, 1'b1, 3'd0}) begin
        errors++;
        $display("FAIL reset0 cyc=%0d got=%h", i, {busy0, oe0, sel0, mv0, rdy0, cnt0});
      end
    end
    wv = 1'b0;
    v0 = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, cnt} !== 4'h0) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=0", {busy, cnt});
    end
  endtask

  task automatic test_nibbles;
    logic [15:0] w;
    logic [21:0] exp, got;
    int k, d, ph;
    w = 16'h12AF;
    wd = w;
    wv = 1'b1;
    for (int cyc = 1; cyc <= 27; cyc++) begin
      tick();
      if (cyc == 1) begin
        wv = 1'b0;
        checks++;
        if (cnt !== 3'd1) begin
          errors++;
          $display("FAIL nib_count got=%0d exp=1", cnt);
        end
      end
      if (cyc == 1 || cyc >= 26) begin
        exp = '0;
      end else begin
        k  = cyc - 2;
        d  = 3 - k / 6;
        ph = k % 6;
        exp[21]    = 1'b1;
        exp[20]    = (ph < 4);
        exp[19:16] = 4'b0001 << d;
        exp[15:0]  = (ph < 4) ? {12'h0, w[4*d +: 4]} : 16'h0;
      end
      got = {busy, oe, sel, mv};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL nib cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] w [6];
    logic [15:0] got [6];
    logic [15:0] acc;
    int push_cyc [6];
    int nw, nn, np;
    logic r, prev_oe;
    w[0] = 16'h0123; w[1] = 16'h4567; w[2] = 16'h89AB;
    w[3] = 16'hCDEF; w[4] = 16'hA5A5; w[5] = 16'h3C3C;
    for (int i = 0; i < 6; i++) begin
      got[i] = '0;
      push_cyc[i] = 0;
    end
    acc = '0; nw = 0; nn = 0; np = 0;
    prev_oe = oe;
    wd = w[0];
    wv = 1'b1;
    r = rdy;
    for (int cyc = 1; cyc <= 160; cyc++) begin
      tick();
      if (wv && r) begin
        push_cyc[np] = cyc;
        np++;
        if (np < 6) wd = w[np];
        else wv = 1'b0;
      end
      r = rdy;
      if (oe && !prev_oe) begin
        acc = {acc[11:0], mv[3:0]};
        nn++;
        if (nn % 4 == 0 && nw < 6) begin
          got[nw] = acc;
          nw++;
        end
      end
      prev_oe = oe;
      if (cyc == 5) begin
        checks++;
        if ({rdy, cnt} !== {1'b0, 3'd4}) begin
          errors++;
          $display("FAIL bp_full got=%h exp=%h", {rdy, cnt}, {1'b0, 3'd4});
        end
      end
      if (cyc == 25) begin
        checks++;
        if ({rdy, cnt} !== {1'b0, 3'd4}) begin
          errors++;
          $display("FAIL bp_hold got=%h exp=%h", {rdy, cnt}, {1'b0, 3'd4});
        end
      end
      if (cyc == 26) begin
        checks++;
        if ({rdy, cnt} !== {1'b1, 3'd3}) begin
          errors++;
          $display("FAIL bp_pop got=%h exp=%h", {rdy, cnt}, {1'b1, 3'd3});
        end
      end
    end
    checks++;
    if (push_cyc[5] !== 27) begin
      errors++;
      $display("FAIL bp_w5_accept got=%0d exp=27", push_cyc[5]);
    end
    checks++;
    if (nw !== 6) begin
      errors++;
      $display("FAIL bp_words got=%0d exp=6", nw);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== w[i]) begin
        errors++;
        $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], w[i]);
      end
    end
    checks++;
    if ({busy, cnt} !== 4'h0) begin
      errors++;
      $display("FAIL bp_drain got=%h exp=0", {busy, cnt});
    end
  endtask

  task automatic test_push_pop;
    logic [15:0] a, b, c, d;
    a = 16'h1111; b = 16'h2345; c = 16'h6789; d = 16'hFEDC;
    wd = a;
    wv = 1'b1;
    for (int cyc = 1; cyc <= 105; cyc++) begin
      tick();
      if (cyc == 1) wd = b;
      if (cyc == 2) wd = c;
      if (cyc == 3) begin
        wv = 1'b0;
        checks++;
        if (cnt !== 3'd2) begin
          errors++;
          $display("FAIL pp_fill got=%0d exp=2", cnt);
        end
      end
      if (cyc == 25) begin
        wv = 1'b1;
        wd = d;
        checks++;
        if ({busy, oe, sel, cnt} !== {2'b10, 4'b0001, 3'd2}) begin
          errors++;
          $display("FAIL pp_gap got=%h exp=%h", {busy, oe, sel, cnt}, {2'b10, 4'b0001, 3'd2});
        end
      end
      if (cyc == 26) begin
        wv = 1'b0;
        checks++;
        if ({oe, sel, mv, cnt} !== {1'b1, 4'b1000, 12'h0, b[15:12], 3'd2}) begin
          errors++;
          $display("FAIL pp_b2b got=%h exp=%h", {oe, sel, mv, cnt},
                   {1'b1, 4'b1000, 12'h0, b[15:12], 3'd2});
        end
      end
      if (cyc == 74) begin
        checks++;
        if ({busy, oe, mv, cnt} !== {2'b11, 12'h0, d[15:12], 3'd0}) begin
          errors++;
          $display("FAIL pp_last got=%h exp=%h", {busy, oe, mv, cnt},
                   {2'b11, 12'h0, d[15:12], 3'd0});
        end
      end
      if (cyc == 97) begin
        checks++;
        if ({busy, oe, sel} !== {2'b10, 4'b0001}) begin
          errors++;
          $display("FAIL pp_endgap got=%h exp=%h", {busy, oe, sel}, {2'b10, 4'b0001});
        end
      end
      if (cyc == 98) begin
        checks++;
        if ({busy, oe, sel, mv} !== 22'h0) begin
          errors++;
          $display("FAIL pp_idle got=%h exp=0", {busy, oe, sel, mv});
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] e [4];
    e[0] = 16'hABCD; e[1] = 16'h1357; e[2] = 16'h2468; e[3] = 16'h9999;
    wd = e[0];
    wv = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      tick();
      if (cyc < 4) wd = e[cyc];
      if (cyc == 4) wv = 1'b0;
      if (cyc == 9) begin
        checks++;
        if ({oe, sel, mv, cnt} !== {1'b1, 4'b0100, 12'h0, e[0][11:8], 3'd3}) begin
          errors++;
          $display("FAIL rm_pre got=%h exp=%h", {oe, sel, mv, cnt},
                   {1'b1, 4'b0100, 12'h0, e[0][11:8], 3'd3});
        end
        rst_n = 1'b0;
      end
      if (cyc == 10) begin
        rst_n = 1'b1;
        checks++;
        if ({busy, oe, sel, mv, rdy, cnt} !== {2'b00, 4'h0, 16'h0, 1'b1, 3'd0}) begin
          errors++;
          $display("FAIL rm_post got=%h", {busy, oe, sel, mv, rdy, cnt});
        end
      end
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      checks++;
      if ({busy, oe, cnt} !== 5'h0) begin
        errors++;
        $display("FAIL rm_quiet cyc=%0d got=%h exp=0", cyc, {busy, oe, cnt});
      end
    end
  endtask

  task automatic test_no_gap;
    logic [21:0] exp, got;
    logic [3:0]  s;
    d0 = 16'h0000;
    v0 = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      tick();
      if (cyc == 1) begin
        v0 = 1'b0;
        checks++;
        if (cnt0 !== 3'd1) begin
          errors++;
          $display("FAIL ng_count got=%0d exp=1", cnt0);
        end
      end
      s = 4'b1000;
      if (cyc >= 2 && cyc <= 13) exp = {2'b11, s >> ((cyc - 2) / 3), 16'h0};
      else exp = '0;
      got = {busy0, oe0, sel0, mv0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ng cyc=%0d got=%h exp=%h", cyc, got, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wv = 1'b0; wd = '0;
    v0 = 1'b0; d0 = '0;
    test_reset();
    test_nibbles();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_no_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
